// File: rtl/transmissor_seq.sv
// -----------------------------------------------------------------------------
// transmissor_seq
//
// Buffers up to PROF 3-bit symbol indices and, on request, transmits them in
// order as 7-segment codes to a downstream sequence detector. Each symbol is
// presented for exactly one clock with ctrl high. Consecutive symbols are
// separated by GAP idle clocks with ctrl low and a blank code. A transmission
// ends with a one-cycle fim pulse, after which the buffer is emptied.
//
// All outputs except cheio are registered. They are loaded from the next-state
// values, so ctrl rises on the same edge that samples inicio. The outputs then
// stay stable through the falling edge, where the detector samples them.
//
// Parameters
//   PROF    symbol buffer depth, 1..8
//   GAP     idle clocks between transmitted symbols, 0..15
//
// Ports
//   clk      rising-edge clock
//   res      asynchronous, active-high reset
//   simbolo  symbol index to append
//   escreve  append simbolo (idle only, ignored when full)
//   inicio   start transmitting the buffered symbols (idle only)
//   codigo   registered 7-segment code, blank whenever ctrl is low
//   ctrl     registered strobe, one clock per transmitted symbol
//   ocupado  registered, high for the whole transmission including fim
//   fim      registered one-cycle end-of-transmission pulse
//   nivel    number of stored symbols
//   cheio    high when nivel equals PROF
// -----------------------------------------------------------------------------
module transmissor_seq #(
   parameter int PROF = 8,
   parameter int GAP  = 2
) (
   input  logic       clk,
   input  logic       res,
   input  logic [2:0] simbolo,
   input  logic       escreve,
   input  logic       inicio,
   output logic [6:0] codigo,
   output logic       ctrl,
   output logic       ocupado,
   output logic       fim,
   output logic [3:0] nivel,
   output logic       cheio
);

   typedef enum logic [1:0] {
      OCIOSO = 2'd0,
      ENVIA  = 2'd1,
      PAUSA  = 2'd2,
      FIM    = 2'd3
   } state_t;

   localparam logic [6:0] BLANK   = 7'b1111111;
   localparam logic [3:0] PROF_L  = 4'(PROF);
   localparam bit         HAS_GAP = (GAP > 0);
   // The pause counter is loaded with GAP-1 and counts down to zero, which
   // gives exactly GAP cycles in PAUSA.
   localparam logic [3:0] GAP_M1  = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

   // Symbol index to 7-segment code. Index 5 is the abort code. It is sent
   // like any other symbol, and the detector gives it its meaning.
   function automatic logic [6:0] map_code(input logic [2:0] s);
      logic [6:0] c;
      case (s)
         3'd0:    c = 7'b0010000;
         3'd1:    c = 7'b0100100;
         3'd2:    c = 7'b0000010;
         3'd3:    c = 7'b1000111;
         3'd4:    c = 7'b0111010;
         3'd5:    c = 7'b0101001;
         default: c = BLANK;
      endcase
      return c;
   endfunction

   // ---------------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------------
   state_t     state, state_d;
   logic [2:0] wp, wp_d;
   logic [2:0] rp, rp_d;
   logic [3:0] nivel_q, nivel_d;
   logic [3:0] gap_cnt, gap_cnt_d;
   logic       wr_en;

   logic [2:0] buf_q [PROF];

   // Next-value outputs, registered below
   logic [6:0] codigo_d;
   logic       ctrl_d;
   logic       ocupado_d;
   logic       fim_d;

   assign nivel = nivel_q;
   assign cheio = (nivel_q == PROF_L);

   // ---------------------------------------------------------------------------
   // Process 1: state register. Reset aborts any transmission at once, without
   // a further ctrl or fim pulse.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state   <= OCIOSO;
         wp      <= '0;
         rp      <= '0;
         nivel_q <= '0;
         gap_cnt <= '0;
         codigo  <= BLANK;
         ctrl    <= 1'b0;
         ocupado <= 1'b0;
         fim     <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments, so every
         // register here samples values from before this edge.
         state   <= state_d;
         wp      <= wp_d;
         rp      <= rp_d;
         nivel_q <= nivel_d;
         gap_cnt <= gap_cnt_d;
         codigo  <= codigo_d;
         ctrl    <= ctrl_d;
         ocupado <= ocupado_d;
         fim     <= fim_d;
      end
   end

   // NOTE: the symbol storage has no reset. Its contents are only read below
   // nivel, and nivel is cleared by reset, so stale data is never observed.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         buf_q[wp] <= simbolo;
      end
   end

   // ---------------------------------------------------------------------------
   // Process 2: next-state and datapath update logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default first, so no path leaves one
      // unassigned and no latch is inferred.
      state_d   = state;
      wp_d      = wp;
      rp_d      = rp;
      nivel_d   = nivel_q;
      gap_cnt_d = gap_cnt;
      wr_en     = 1'b0;

      case (state)
         OCIOSO: begin
            // inicio wins over a simultaneous escreve, which is dropped
            if (inicio) begin
               rp_d = '0;
               if (nivel_q != 4'd0) begin
                  state_d = ENVIA;
               end else begin
                  state_d = FIM;
               end
            end else if (escreve && !cheio) begin
               wr_en   = 1'b1;
               wp_d    = wp + 3'd1;
               nivel_d = nivel_q + 4'd1;
            end
         end

         ENVIA: begin
            // More symbols remain while rp+1 < nivel. This form avoids
            // underflow in nivel-1.
            if (({1'b0, rp} + 4'd1) < nivel_q) begin
               if (HAS_GAP) begin
                  state_d   = PAUSA;
                  gap_cnt_d = GAP_M1;
               end else begin
                  state_d = ENVIA;
                  rp_d    = rp + 3'd1;
               end
            end else begin
               state_d = FIM;
            end
         end

         PAUSA: begin
            if (gap_cnt == 4'd0) begin
               state_d = ENVIA;
               rp_d    = rp + 3'd1;
            end else begin
               gap_cnt_d = gap_cnt - 4'd1;
            end
         end

         FIM: begin
            // The buffer is emptied only on leaving FIM. This keeps nivel
            // stable for the whole transmission.
            state_d = OCIOSO;
            wp_d    = '0;
            rp_d    = '0;
            nivel_d = '0;
         end

         default: begin
            state_d = OCIOSO;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Process 3: output logic. The outputs are decoded from the next state and
   // then registered. This places ctrl/codigo in the same cycle as the state
   // they describe, with no combinational path to the pins.
   // ---------------------------------------------------------------------------
   always_comb begin
      ctrl_d    = (state_d == ENVIA);
      fim_d     = (state_d == FIM);
      ocupado_d = (state_d != OCIOSO);
      codigo_d  = BLANK;
      if (state_d == ENVIA) begin
         codigo_d = map_code(buf_q[rp_d]);
      end
   end

endmodule
